// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: loads N instruction words from a valid/ready word stream
// into the core's instruction memory, then releases the core from reset.
//
// Sequence: IDLE -> LOAD (write words at addresses 0..len-1) -> HOLD
// (ProgMode=1, cpu_reset held for RST_HOLD_CYC cycles) -> RUN.
//
// Optional feature, macro PROG_CKSUM_EN: when defined, LOAD accepts one
// extra word after the len-th word. That word is compared with the
// modulo-2^DATA_W sum of all written words. A match proceeds to HOLD; a
// mismatch sets err and returns to IDLE. When undefined, HOLD follows the
// len-th word directly.
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready is high exactly while the FSM is in LOAD. The source may hold or
// drop s_valid freely; a word presented while s_ready is low is not taken.
// Each transferred data word produces one prog_we pulse on the next cycle.
//
// State encoding exposed on state_dbg: 0=IDLE, 1=LOAD, 2=HOLD, 3=RUN.

module prog_load_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int RST_HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ProgMode,
  output logic [ADDR_W-1:0] Addr_Prog,
  output logic [DATA_W-1:0] Data_Prog,
  output logic              prog_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Largest legal word count: the full memory, 2^ADDR_W words.
  localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      HOLD_END = 4'(RST_HOLD_CYC);

  state_t            state;
  logic [ADDR_W:0]   len_q;     // latched word count
  logic [ADDR_W:0]   cnt;       // words written so far = next write address
  logic [3:0]        hold_cnt;  // HOLD-phase cycle counter
`ifdef PROG_CKSUM_EN
  logic [DATA_W-1:0] sum;       // running modulo-2^DATA_W sum of written words
`endif

  logic xfer;
  logic len_ok;

  // Handshake and request qualification.
  always_comb begin
    xfer   = s_valid && s_ready;
    len_ok = (len != '0) && (len <= MAX_LEN);
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    s_ready   = (state == ST_LOAD);
    busy      = (state == ST_LOAD) || (state == ST_HOLD);
    done      = (state == ST_RUN);
    state_dbg = state;
  end

  // Main sequencer: state, counters, and registered core-facing outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      hold_cnt  <= '0;
      ProgMode  <= 1'b0;
      Addr_Prog <= '0;
      Data_Prog <= '0;
      prog_we   <= 1'b0;
      cpu_reset <= 1'b1;
      err       <= 1'b0;
`ifdef PROG_CKSUM_EN
      sum       <= '0;
`endif
    end else begin
      // The write strobe is a single-cycle pulse unless a transfer re-arms it.
      prog_we <= 1'b0;

      if (abort) begin
        // Abort drops any write that a same-cycle transfer would have caused;
        // err is left as it was.
        state     <= ST_IDLE;
        cpu_reset <= 1'b1;
        ProgMode  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cpu_reset <= 1'b1;
            ProgMode  <= 1'b0;
            if (start) begin
              if (len_ok) begin
                len_q <= len;
                cnt   <= '0;
                err   <= 1'b0;
`ifdef PROG_CKSUM_EN
                sum   <= '0;
`endif
                state <= ST_LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end

          ST_LOAD: begin
            cpu_reset <= 1'b1;
            ProgMode  <= 1'b0;
            if (xfer) begin
`ifdef PROG_CKSUM_EN
              if (cnt == len_q) begin
                // Trailing checksum word: never written to memory.
                if (s_data == sum) begin
                  hold_cnt <= '0;
                  state    <= ST_HOLD;
                end else begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
                end
              end else begin
                Addr_Prog <= cnt[ADDR_W-1:0];
                Data_Prog <= s_data;
                prog_we   <= 1'b1;
                sum       <= sum + s_data;
                cnt       <= cnt + 1'b1;
              end
`else
              Addr_Prog <= cnt[ADDR_W-1:0];
              Data_Prog <= s_data;
              prog_we   <= 1'b1;
              cnt       <= cnt + 1'b1;
              if (cnt == len_q - 1'b1) begin
                hold_cnt <= '0;
                state    <= ST_HOLD;
              end
`endif
            end
          end

          ST_HOLD: begin
            // First HOLD cycle carries the last write with ProgMode still 0;
            // ProgMode rises after it and cpu_reset stays high for
            // RST_HOLD_CYC further cycles.
            ProgMode <= 1'b1;
            if (hold_cnt == HOLD_END) begin
              cpu_reset <= 1'b0;
              state     <= ST_RUN;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end

          ST_RUN: begin
            // Start is ignored here; only abort or reset leave RUN.
            ProgMode  <= 1'b1;
            cpu_reset <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Testbench for prog_load_ctrl: randomized word loads checked against a
// queue-based model of the expected memory writes and of the release timing.
// Builds with or without PROG_CKSUM_EN.

module tb_prog_load_ctrl;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 32;
  localparam int RST_HOLD_CYC = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              abort = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic              ProgMode;
  logic [ADDR_W-1:0] Addr_Prog;
  logic [DATA_W-1:0] Data_Prog;
  logic              prog_we;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt = 0;
  int last_we_cyc = -1;
  int last_xfer_cyc = -100;
  int xfer_cyc = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] mon_e;
  logic [DATA_W-1:0]        wbuf[256];

  prog_load_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD_CYC(RST_HOLD_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ProgMode(ProgMode), .Addr_Prog(Addr_Prog), .Data_Prog(Data_Prog),
    .prog_we(prog_we), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write must match the head of exp_q and follow a
  // transfer on the immediately preceding cycle.
  always @(negedge clk) begin
    if (prog_we) begin
      we_cnt++;
      last_we_cyc = cyc;
      checks++;
      if (last_xfer_cyc != cyc - 1) begin
        errors++;
        $display("FAIL write_latency: write at cycle %0d, last transfer cycle %0d, required %0d",
                 cyc, last_xfer_cyc, cyc - 1);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", Addr_Prog, Data_Prog);
      end else begin
        mon_e = exp_q.pop_front();
        if ({Addr_Prog, Data_Prog} !== mon_e) begin
          errors++;
          $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   Addr_Prog, Data_Prog, mon_e[ADDR_W+DATA_W-1:DATA_W], mon_e[DATA_W-1:0]);
        end
      end
    end
    if (s_valid && s_ready) last_xfer_cyc = cyc;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Present one word after 'gap' idle cycles and hold it until accepted.
  task automatic send_word(input logic [DATA_W-1:0] d, input int gap);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = d;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (s_ready) begin
        xfer_cyc = cyc;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    s_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake_timeout: word %h not accepted, s_ready=%b required 1", d, s_ready);
    end
  endtask

  // Start a load of n words from wbuf. gapmode: 0 continuous, 1 random gaps,
  // 2 fixed two-cycle gaps. bad_ck sends a wrong checksum when enabled.
  task automatic do_load(input int n, input int gapmode, input bit bad_ck);
    logic [DATA_W-1:0] sum;
    int g;
    sum = '0;
    start = 1'b1;
    len   = (ADDR_W+1)'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), wbuf[i]});
      sum = sum + wbuf[i];
      g = (gapmode == 0) ? 0 : (gapmode == 1) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : 2);
      send_word(wbuf[i], g);
    end
`ifdef PROG_CKSUM_EN
    send_word(bad_ck ? sum + 1 : sum, 0);
`else
    if (bad_ck) sum = '0;
`endif
  endtask

  // Wait for RUN; return the first cycles with ProgMode=1 and cpu_reset=0.
  task automatic wait_run(output int pm_c, output int rf_c);
    pm_c = -1;
    rf_c = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ProgMode && pm_c < 0) pm_c = cyc;
      if (!cpu_reset) begin
        rf_c = cyc;
        break;
      end
    end
    checks++;
    if (rf_c < 0) begin
      errors++;
      $display("FAIL run_timeout: cpu_reset still %b after 40 cycles, required 0", cpu_reset);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ProgMode, prog_we, cpu_reset, s_ready, busy, done, err} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_flags: got PM/we/crst/rdy/busy/done/err=%b required 0010000",
               {ProgMode, prog_we, cpu_reset, s_ready, busy, done, err});
    end
    checks++;
    if (Addr_Prog !== '0 || Data_Prog !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%0d data=%h required 0/0", Addr_Prog, Data_Prog);
    end
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", state_dbg, S_IDLE);
    end
  endtask

  task automatic test_basic();
    int pm_c, rf_c, w0;
    w0 = we_cnt;
    wbuf[0] = 32'h10606FDE;
    wbuf[1] = 32'h10400000;
    wbuf[2] = 32'h10200001;
    do_load(3, 0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    wait_run(pm_c, rf_c);
    checks++;
    if (pm_c != xfer_cyc + 2) begin
      errors++;
      $display("FAIL basic_progmode_cycle: got %0d required %0d", pm_c, xfer_cyc + 2);
    end
    checks++;
    if (rf_c != pm_c + RST_HOLD_CYC) begin
      errors++;
      $display("FAIL basic_release_cycle: got %0d required %0d", rf_c, pm_c + RST_HOLD_CYC);
    end
    checks++;
    if (we_cnt - w0 != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_writes: got %0d writes, %0d pending, required 3, 0", we_cnt - w0, exp_q.size());
    end
    checks++;
    if ({done, busy, ProgMode, state_dbg} !== {3'b101, S_RUN}) begin
      errors++;
      $display("FAIL basic_run: got done/busy/PM/state=%b required %b", {done, busy, ProgMode, state_dbg}, {3'b101, S_RUN});
    end
    go_idle();
  endtask

  task automatic test_gaps();
    int pm_c, rf_c, w0;
    w0 = we_cnt;
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_load(4, 2, 1'b0);
    wait_run(pm_c, rf_c);
    checks++;
    if (we_cnt - w0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gaps_writes: got %0d writes, %0d pending, required 4, 0", we_cnt - w0, exp_q.size());
    end
    go_idle();
    w0 = we_cnt;
    for (int i = 0; i < 12; i++) wbuf[i] = $urandom;
    do_load(12, 1, 1'b0);
    wait_run(pm_c, rf_c);
    checks++;
    if (we_cnt - w0 != 12 || done !== 1'b1) begin
      errors++;
      $display("FAIL random_gaps: got %0d writes done=%b, required 12 writes done=1", we_cnt - w0, done);
    end
    go_idle();
  endtask

  task automatic test_len_max();
    int pm_c, rf_c, w0;
    w0 = we_cnt;
    for (int i = 0; i < 256; i++) wbuf[i] = DATA_W'(i);
    do_load(256, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (Addr_Prog !== 8'd255 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL max_last: got addr=%0d s_ready=%b required 255, 0", Addr_Prog, s_ready);
    end
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (5) tick();
    s_valid = 1'b0;
    checks++;
    if (we_cnt - w0 != 256 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_count: got %0d writes, %0d pending, required 256, 0", we_cnt - w0, exp_q.size());
    end
    wait_run(pm_c, rf_c);
    go_idle();
  endtask

  task automatic test_len_zero();
    int w0;
    w0 = we_cnt;
    start = 1'b1;
    len   = '0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || state_dbg !== S_IDLE || busy !== 1'b0 || we_cnt != w0) begin
      errors++;
      $display("FAIL len_zero: got err=%b state=%0d busy=%b writes=%0d required 1,0,0,0",
               err, state_dbg, busy, we_cnt - w0);
    end
    // Start together with abort: abort wins, err untouched, no load.
    start = 1'b1;
    abort = 1'b1;
    len   = 9'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_abort: got err=%b busy=%b s_ready=%b required 1,0,0", err, busy, s_ready);
    end
    // len above the memory size is also rejected.
    start = 1'b1;
    len   = 9'd257;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_over: got err=%b busy=%b required 1,0", err, busy);
    end
    // A valid start clears err.
    wbuf[0] = $urandom;
    do_load(1, 0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b required 0", err);
    end
    go_idle();
    repeat (2) tick();
  endtask

  task automatic test_abort();
    int w0, pm_c, rf_c;
    w0 = we_cnt;
    for (int i = 0; i < 10; i++) wbuf[i] = $urandom;
    start = 1'b1;
    len   = 9'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({ADDR_W'(i), wbuf[i]});
      send_word(wbuf[i], 0);
    end
    go_idle();
    @(negedge clk);
    checks++;
    if (state_dbg !== S_IDLE || cpu_reset !== 1'b1 || ProgMode !== 1'b0 || we_cnt - w0 != 5) begin
      errors++;
      $display("FAIL abort_load: got state=%0d crst=%b PM=%b writes=%0d required 0,1,0,5",
               state_dbg, cpu_reset, ProgMode, we_cnt - w0);
    end
    // Reload from address 0.
    w0 = we_cnt;
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    do_load(2, 0, 1'b0);
    wait_run(pm_c, rf_c);
    checks++;
    if (we_cnt - w0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_reload: got %0d writes, %0d pending, required 2, 0", we_cnt - w0, exp_q.size());
    end
    go_idle();
    // Abort in the same cycle as a transfer drops that write.
    w0 = we_cnt;
    start = 1'b1;
    len   = 9'd6;
    tick();
    start = 1'b0;
    wbuf[0] = $urandom;
    exp_q.push_back({ADDR_W'(0), wbuf[0]});
    send_word(wbuf[0], 0);
    s_valid = 1'b1;
    s_data  = $urandom;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (we_cnt - w0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_drop: got %0d writes, %0d pending, required 1, 0", we_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_run_restart();
    int w0, pm_c, rf_c;
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    do_load(3, 1, 1'b0);
    wait_run(pm_c, rf_c);
    w0 = we_cnt;
    start = 1'b1;
    len   = 9'd5;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || state_dbg !== S_RUN || we_cnt != w0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_start_ignored: got done=%b state=%0d writes=%0d rdy=%b required 1,3,0,0",
               done, state_dbg, we_cnt - w0, s_ready);
    end
    go_idle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || state_dbg !== S_IDLE || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL run_abort: got done=%b state=%0d crst=%b required 0,0,1", done, state_dbg, cpu_reset);
    end
    // Reset pulse during HOLD.
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    do_load(2, 0, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ProgMode, prog_we, cpu_reset, s_ready, busy, done, err} !== 7'b0010000 ||
        Addr_Prog !== '0 || Data_Prog !== '0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL hold_reset: got flags=%b addr=%0d data=%h state=%0d required 0010000,0,0,0",
               {ProgMode, prog_we, cpu_reset, s_ready, busy, done, err}, Addr_Prog, Data_Prog, state_dbg);
    end
  endtask

`ifdef PROG_CKSUM_EN
  task automatic test_cksum();
    int w0, pm_c, rf_c;
    w0 = we_cnt;
    wbuf[0] = 32'd5;
    wbuf[1] = 32'd7;
    do_load(2, 0, 1'b0);
    wait_run(pm_c, rf_c);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || we_cnt - w0 != 2) begin
      errors++;
      $display("FAIL cksum_good: got done=%b err=%b writes=%0d required 1,0,2", done, err, we_cnt - w0);
    end
    go_idle();
    w0 = we_cnt;
    do_load(2, 0, 1'b1);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || state_dbg !== S_IDLE || cpu_reset !== 1'b1 || ProgMode !== 1'b0 || we_cnt - w0 != 2) begin
      errors++;
      $display("FAIL cksum_bad: got err=%b state=%0d crst=%b PM=%b writes=%0d required 1,0,1,0,2",
               err, state_dbg, cpu_reset, ProgMode, we_cnt - w0);
    end
  endtask
`endif

  // Test sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_len_max();
    test_len_zero();
    test_abort();
    test_run_restart();
`ifdef PROG_CKSUM_EN
    test_cksum();
`endif
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
